bcd_run_ctrl: RTL

Run-control sequencer for a chain of cascaded BCD digit counters. It owns the digit registers, a shared count-rate prescaler and a command port with a ready/valid handshake. It uses a four-state FSM to start, pause, clear and preload the chain, and to stop on a programmable BCD limit. It sits between the system command bus and display/compare logic that consumes the packed BCD count.

---
 rtl/bcd_run_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bcd_run_ctrl.sv
// Run-control sequencer for a chain of cascaded BCD digit counters.
// Handles start/stop/clear/load commands and stops when the count reaches a programmable BCD limit.
module bcd_run_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [4*DIGITS-1:0] cmd_data,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                tick,
  output logic                ovf,
  output logic                cmd_err
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;
  typedef enum logic [1:0] {OP_START = 2'b00, OP_STOP = 2'b01,
                            OP_CLEAR = 2'b10, OP_LOAD = 2'b11} op_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   limit, limit_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [CW-1:0]   count_nxt, count_inc, data_sat;
  logic            all_nines, carry, presc_last, accept, can_cmd;
  logic            do_inc, tick_nxt, ovf_nxt, err_nxt;
  op_t             op;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_sat  = cmd_data;
    count_inc = count;
    all_nines = 1'b1;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cmd_data[4*i +: 4] > 4'd9) data_sat[4*i +: 4] = 4'd9;
      if (count[4*i +: 4] != 4'd9) all_nines = 1'b0;
      // Ripple carry: a digit moves only when every lower digit is 9.
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  assign op         = op_t'(cmd_op);
  assign accept     = cmd_valid & cmd_ready;
  assign presc_last = (presc == PW'(PRESCALE - 1));
  assign can_cmd    = (state == ST_IDLE) || (state == ST_PAUSE);
  // STOP and CLEAR swallow an increment landing on the same edge; failed commands do not.
  assign do_inc     = (state == ST_RUN) && presc_last &&
                      !(accept && (op == OP_STOP || op == OP_CLEAR));

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    limit_nxt = limit;
    presc_nxt = presc;
    tick_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    err_nxt   = 1'b0;

    if (state == ST_RUN) presc_nxt = presc_last ? '0 : presc + PW'(1);

    if (do_inc) begin
      count_nxt = count_inc;
      tick_nxt  = 1'b1;
      ovf_nxt   = all_nines;
      if (count_inc == limit) state_nxt = ST_DONE;
    end

    if (accept) begin
      unique case (op)
        OP_START: begin
          if (can_cmd) begin
            limit_nxt = data_sat;
            state_nxt = (count == data_sat) ? ST_DONE : ST_RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
        OP_STOP: begin
          if (state == ST_RUN) state_nxt = ST_PAUSE;
          else                 err_nxt   = 1'b1;
        end
        OP_CLEAR: begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
          presc_nxt = '0;
        end
        OP_LOAD: begin
          if (can_cmd) count_nxt = data_sat;
          else         err_nxt   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      limit     <= '0;
      presc     <= '0;
      cmd_ready <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      tick      <= 1'b0;
      ovf       <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      limit     <= limit_nxt;
      presc     <= presc_nxt;
      cmd_ready <= 1'b1;
      running   <= (state_nxt == ST_RUN);
      done      <= (state_nxt == ST_DONE);
      tick      <= tick_nxt;
      ovf       <= ovf_nxt;
      cmd_err   <= err_nxt;
    end
  end

endmodule
